fir_sequencer: RTL and testbench

Control FSM for the FIR filter datapath. It sits between the AHB-lite slave and the datapath register file and multiplier/ALU. It turns the slave's `data_ready` and `new_coefficient_set` pulses into a fixed sequence of datapath micro-ops: coefficient loads, sample shift, and a four-tap multiply-accumulate. It also reports `modwait` and `err` back for the status register.

---
 rtl/fir_seq_pkg.sv | 63 ++++++
 rtl/fir_sequencer.sv | 143 ++++++++++++++
 tb/tb_fir_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_pkg.sv
// ============================================================================
// Module      : fir_seq_pkg
// Description : Shared types and constants for the FIR control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD1 = 3'd2,
    OP_LOAD2 = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } op_e;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] ST_IDLE  = 5'd0;
  localparam logic [STATE_W-1:0] ST_LC0   = 5'd1;
  localparam logic [STATE_W-1:0] ST_LC1   = 5'd2;
  localparam logic [STATE_W-1:0] ST_LC2   = 5'd3;
  localparam logic [STATE_W-1:0] ST_LC3   = 5'd4;
  localparam logic [STATE_W-1:0] ST_SH3   = 5'd5;
  localparam logic [STATE_W-1:0] ST_SH2   = 5'd6;
  localparam logic [STATE_W-1:0] ST_SH1   = 5'd7;
  localparam logic [STATE_W-1:0] ST_LDS   = 5'd8;
  localparam logic [STATE_W-1:0] ST_M1    = 5'd9;
  localparam logic [STATE_W-1:0] ST_MV    = 5'd10;
  localparam logic [STATE_W-1:0] ST_M2    = 5'd11;
  localparam logic [STATE_W-1:0] ST_S2    = 5'd12;
  localparam logic [STATE_W-1:0] ST_M3    = 5'd13;
  localparam logic [STATE_W-1:0] ST_A3    = 5'd14;
  localparam logic [STATE_W-1:0] ST_M4    = 5'd15;
  localparam logic [STATE_W-1:0] ST_S4    = 5'd16;
  localparam logic [STATE_W-1:0] ST_DONE  = 5'd17;
  localparam logic [STATE_W-1:0] ST_EIDLE = 5'd18;

  localparam logic [3:0] R0 = 4'd0;
  localparam logic [3:0] R1 = 4'd1;
  localparam logic [3:0] R2 = 4'd2;
  localparam logic [3:0] R3 = 4'd3;
  localparam logic [3:0] R4 = 4'd4;
  localparam logic [3:0] R5 = 4'd5;
  localparam logic [3:0] R6 = 4'd6;
  localparam logic [3:0] R7 = 4'd7;
  localparam logic [3:0] R8 = 4'd8;
  localparam logic [3:0] R9 = 4'd9;

  localparam logic [3:0] COEF_BASE = R5;

  // States whose datapath op can raise overflow
  function automatic logic is_arith_state(input logic [STATE_W-1:0] s);
    return (s == ST_M1) || (s == ST_M2) || (s == ST_S2) || (s == ST_M3) ||
           (s == ST_A3) || (s == ST_M4) || (s == ST_S4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sequencer.sv
// ============================================================================
// Module      : fir_sequencer
// Description : Control FSM turning sample/coefficient pulses into FIR micro-ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sequencer
  import fir_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       data_ready,
  input  logic       new_coefficient_set,
  input  logic       overflow,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic [1:0] coefficient_num,
  output logic       modwait,
  output logic       err,
  output logic       cnt_up
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               pend_dr_q, pend_dr_d;
  logic               pend_lc_q, pend_lc_d;
  logic               err_q, err_d;

  logic               dr_req, lc_req;
  logic               start_lc, start_sh;
  logic               arith_ovf;

  op_e                op_sel;
  logic [1:0]         lc_idx;

  // ---------------------------------------------------------------------------
  // Next-state and bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    dr_req    = pend_dr_q | data_ready;
    lc_req    = pend_lc_q | new_coefficient_set;
    arith_ovf = is_arith_state(state_q) & overflow;
    state_d   = state_q;

    case (state_q)
      ST_IDLE, ST_EIDLE: begin
        if (lc_req) begin
          state_d = ST_LC0;
        end else if (dr_req) begin
          state_d = ST_SH3;
        end
      end
      ST_LC0:  state_d = ST_LC1;
      ST_LC1:  state_d = ST_LC2;
      ST_LC2:  state_d = ST_LC3;
      ST_LC3:  state_d = ST_IDLE;
      ST_SH3:  state_d = ST_SH2;
      ST_SH2:  state_d = ST_SH1;
      ST_SH1:  state_d = ST_LDS;
      ST_LDS:  state_d = ST_M1;
      ST_M1:   state_d = ST_MV;
      ST_MV:   state_d = ST_M2;
      ST_M2:   state_d = ST_S2;
      ST_S2:   state_d = ST_M3;
      ST_M3:   state_d = ST_A3;
      ST_A3:   state_d = ST_M4;
      ST_M4:   state_d = ST_S4;
      ST_S4:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (arith_ovf) begin
      state_d = ST_EIDLE;
    end

    // LC0 and SH3 are only ever entered from a dispatch state
    start_lc = (state_d == ST_LC0);
    start_sh = (state_d == ST_SH3);

    pend_lc_d = start_lc ? 1'b0 : (pend_lc_q | new_coefficient_set);
    pend_dr_d = start_sh ? 1'b0 : (pend_dr_q | data_ready);
    err_d     = (start_lc | start_sh) ? 1'b0 : (err_q | arith_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_dr_q <= 1'b0;
      pend_lc_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_dr_q <= pend_dr_d;
      pend_lc_q <= pend_lc_d;
      err_q     <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    op_sel          = OP_NOP;
    src1            = R0;
    src2            = R0;
    dest            = R0;
    coefficient_num = 2'd0;
    modwait         = 1'b1;
    cnt_up          = 1'b0;
    lc_idx          = 2'(state_q - ST_LC0);

    case (state_q)
      ST_LC0, ST_LC1, ST_LC2, ST_LC3: begin
        op_sel          = OP_LOAD2;
        dest            = COEF_BASE + {2'b00, lc_idx};
        coefficient_num = lc_idx;
      end
      ST_SH3: begin op_sel = OP_COPY;  src1 = R3; dest = R4; end
      ST_SH2: begin op_sel = OP_COPY;  src1 = R2; dest = R3; end
      ST_SH1: begin op_sel = OP_COPY;  src1 = R1; dest = R2; end
      ST_LDS: begin op_sel = OP_LOAD1; dest = R1; end
      ST_M1:  begin op_sel = OP_MUL;   src1 = R1; src2 = R5; dest = R9; end
      ST_MV:  begin op_sel = OP_COPY;  src1 = R9; dest = R0; end
      ST_M2:  begin op_sel = OP_MUL;   src1 = R2; src2 = R6; dest = R9; end
      ST_S2:  begin op_sel = OP_SUB;   src1 = R0; src2 = R9; dest = R0; end
      ST_M3:  begin op_sel = OP_MUL;   src1 = R3; src2 = R7; dest = R9; end
      ST_A3:  begin op_sel = OP_ADD;   src1 = R0; src2 = R9; dest = R0; end
      ST_M4:  begin op_sel = OP_MUL;   src1 = R4; src2 = R8; dest = R9; end
      ST_S4:  begin op_sel = OP_SUB;   src1 = R0; src2 = R9; dest = R0; end
      ST_DONE: cnt_up = 1'b1;
      default: modwait = 1'b0;
    endcase
  end

  assign op  = op_sel;
  assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_sequencer.sv
// ============================================================================
// Module      : tb_fir_sequencer
// Description : Self-checking bench: micro-op queue model plus behavioural datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_sequencer;

  localparam logic [2:0] NOP = 3'd0, COPY = 3'd1, LD1 = 3'd2, LD2 = 3'd3,
                         ADD = 3'd4, SUB = 3'd5, MUL = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_ready = 1'b0;
  logic        new_coefficient_set = 1'b0;
  logic        overflow = 1'b0;
  logic [2:0]  op;
  logic [3:0]  src1, src2, dest;
  logic [1:0]  coefficient_num;
  logic        modwait, err, cnt_up;

  fir_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_ready          (data_ready),
    .new_coefficient_set (new_coefficient_set),
    .overflow            (overflow),
    .op                  (op),
    .src1                (src1),
    .src2                (src2),
    .dest                (dest),
    .coefficient_num     (coefficient_num),
    .modwait             (modwait),
    .err                 (err),
    .cnt_up              (cnt_up)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] s1, s2, d;
    logic [1:0] cn;
    logic       cnt;
    logic       lds;
  } uop_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cnt_seen = 0;
  int          last_cnt_cyc = 0;

  // Reference model: queue of micro-ops still to be issued
  uop_t        q[$];
  bit          m_pend_dr, m_pend_lc, m_err;
  logic [15:0] hist[4];
  int          hist_n;
  bit          coef_ok;

  // Behavioural datapath and slave data
  logic [15:0] rf[10];
  logic [15:0] coef[4];
  logic [15:0] sample_data = 16'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic uop_t mk(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] d, input logic [1:0] cn, input bit c, input bit l);
    uop_t u;
    u.op = o; u.s1 = a; u.s2 = b; u.d = d; u.cn = cn; u.cnt = c; u.lds = l;
    return u;
  endfunction

  task automatic push_sample_seq();
    q.push_back(mk(COPY, 4'd3, 4'd0, 4'd4, 2'd0, 0, 0));
    q.push_back(mk(COPY, 4'd2, 4'd0, 4'd3, 2'd0, 0, 0));
    q.push_back(mk(COPY, 4'd1, 4'd0, 4'd2, 2'd0, 0, 0));
    q.push_back(mk(LD1,  4'd0, 4'd0, 4'd1, 2'd0, 0, 1));
    q.push_back(mk(MUL,  4'd1, 4'd5, 4'd9, 2'd0, 0, 0));
    q.push_back(mk(COPY, 4'd9, 4'd0, 4'd0, 2'd0, 0, 0));
    q.push_back(mk(MUL,  4'd2, 4'd6, 4'd9, 2'd0, 0, 0));
    q.push_back(mk(SUB,  4'd0, 4'd9, 4'd0, 2'd0, 0, 0));
    q.push_back(mk(MUL,  4'd3, 4'd7, 4'd9, 2'd0, 0, 0));
    q.push_back(mk(ADD,  4'd0, 4'd9, 4'd0, 2'd0, 0, 0));
    q.push_back(mk(MUL,  4'd4, 4'd8, 4'd9, 2'd0, 0, 0));
    q.push_back(mk(SUB,  4'd0, 4'd9, 4'd0, 2'd0, 0, 0));
    q.push_back(mk(NOP,  4'd0, 4'd0, 4'd0, 2'd0, 1, 0));
  endtask

  task automatic push_coef_seq();
    for (int k = 0; k < 4; k++)
      q.push_back(mk(LD2, 4'd0, 4'd0, 4'(5 + k), 2'(k), 0, 0));
  endtask

  function automatic logic [19:0] model_out();
    if (q.size() > 0)
      return {q[0].op, q[0].s1, q[0].s2, q[0].d, q[0].cn, 1'b1, q[0].cnt, m_err};
    return {17'd0, 1'b0, 1'b0, m_err};
  endfunction

  function automatic logic [15:0] exp_r0();
    logic [15:0] p0, p1, p2, p3;
    p0 = coef[0] * hist[0];
    p1 = coef[1] * hist[1];
    p2 = coef[2] * hist[2];
    p3 = coef[3] * hist[3];
    return p0 - p1 + p2 - p3;
  endfunction

  task automatic dp_exec(input logic [19:0] v);
    logic [2:0] o;
    logic [3:0] a, b, d;
    logic [15:0] res;
    o = v[19:17]; a = v[16:13]; b = v[12:9]; d = v[8:5];
    res = 16'd0;
    if (a < 4'd10 && b < 4'd10 && d < 4'd10) begin
      case (o)
        COPY: res = rf[a];
        LD1:  res = sample_data;
        LD2:  res = coef[v[4:3]];
        ADD:  res = rf[a] + rf[b];
        SUB:  res = rf[a] - rf[b];
        MUL:  res = rf[a] * rf[b];
        default: res = 16'd0;
      endcase
      if (o != NOP) rf[d] = res;
    end
  endtask

  // One clock: compare, drive inputs, advance datapath and model, cross edge
  task automatic cycle(input bit dr, input bit lc, input bit ov, input bit r, input logic [15:0] sv);
    logic [19:0] obs;
    uop_t u;
    bit lc_req, dr_req;
    obs = {op, src1, src2, dest, coefficient_num, modwait, cnt_up, err};
    check_val("outs", 32'(obs), 32'(model_out()));
    if (cnt_up) begin cnt_seen++; last_cnt_cyc = cyc; end
    if (q.size() > 0 && q[0].cnt && hist_n >= 4 && coef_ok)
      check_val("r0", 32'(rf[0]), 32'(exp_r0()));

    data_ready = dr; new_coefficient_set = lc; overflow = ov; rst = r;
    if (dr) sample_data = sv;
    dp_exec(obs);

    if (r) begin
      q.delete(); m_pend_dr = 0; m_pend_lc = 0; m_err = 0; hist_n = 0; coef_ok = 0;
    end else if (q.size() > 0) begin
      u = q.pop_front();
      if (u.lds) begin
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = sample_data;
        if (hist_n < 4) hist_n++;
      end
      if (u.op == LD2 && u.cn == 2'd3) coef_ok = 1;
      if ((u.op == ADD || u.op == SUB || u.op == MUL) && ov) begin
        q.delete(); m_err = 1;
      end
      m_pend_dr |= dr; m_pend_lc |= lc;
    end else begin
      lc_req = m_pend_lc | lc;
      dr_req = m_pend_dr | dr;
      if (lc_req) begin
        push_coef_seq(); m_pend_lc = 0; m_pend_dr = dr_req; m_err = 0;
      end else if (dr_req) begin
        push_sample_seq(); m_pend_dr = 0; m_err = 0;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input bit ov_at_add);
    for (int i = 0; i < 60 && (q.size() > 0 || m_pend_dr || m_pend_lc); i++)
      cycle(0, 0, ov_at_add && q.size() > 0 && q[0].op == ADD, 0, 16'd0);
  endtask

  initial begin
    int base, pulse_cyc;
    logic [15:0] samples[4];
    for (int i = 0; i < 10; i++) rf[i] = 16'd0;
    for (int i = 0; i < 4; i++) begin coef[i] = 16'd1; hist[i] = 16'd0; end
    m_pend_dr = 0; m_pend_lc = 0; m_err = 0; hist_n = 0; coef_ok = 0;
    samples[0] = 16'd10; samples[1] = 16'd20; samples[2] = 16'd30; samples[3] = 16'd40;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_idle", 32'({op, src1, src2, dest, coefficient_num, modwait, cnt_up, err}), 32'd0);

    // Coefficient load, then four samples
    cycle(0, 1, 0, 0, 16'd0);
    drain(0);
    cycle(0, 0, 0, 0, 16'd0);
    pulse_cyc = 0;
    for (int s = 0; s < 4; s++) begin
      pulse_cyc = cyc;
      cycle(1, 0, 0, 0, samples[s]);
      drain(0);
      cycle(0, 0, 0, 0, 16'd0);
    end
    check_val("lat13", 32'(last_cnt_cyc - pulse_cyc), 32'd13);
    check_val("r0_dir", 32'(rf[0]), 32'd20);

    // Overflow in A3
    cycle(1, 0, 0, 0, 16'd55);
    drain(1);
    check_val("err_set", 32'({err, modwait}), 32'b10);
    cycle(1, 0, 0, 0, 16'd66);
    check_val("err_clr", 32'({err, op}), 32'({1'b0, COPY}));
    drain(0);
    cycle(0, 0, 0, 0, 16'd0);

    // Simultaneous pulses
    cycle(1, 1, 0, 0, 16'd77);
    drain(0);
    cycle(0, 0, 0, 0, 16'd0);

    // Merge: two pulses during one sequence
    base = cnt_seen;
    for (int i = 0; i < 40; i++) cycle(i == 0 || i == 3 || i == 6, 0, 0, 0, 16'(100 + i));
    check_val("merge_cnt", 32'(cnt_seen - base), 32'd2);

    // Reset mid-M2
    base = cnt_seen;
    cycle(1, 0, 0, 0, 16'd5);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, q.size() > 0 && q[0].op == MUL && q[0].s1 == 4'd2, 16'd0);
    check_val("rst_mid_cnt", 32'(cnt_seen - base), 32'd0);
    check_val("rst_mid_mw", 32'({modwait, op}), 32'd0);

    // Randomised phase with fresh coefficients
    for (int i = 0; i < 4; i++) coef[i] = 16'($urandom);
    coef_ok = 0;
    cycle(0, 1, 0, 0, 16'd0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0,
            $urandom_range(0, 59) == 0,
            q.size() > 0 && (q[0].op == ADD || q[0].op == SUB || q[0].op == MUL) &&
              $urandom_range(0, 9) == 0,
            $urandom_range(0, 399) == 0,
            16'($urandom));
    end
    drain(0);
    cycle(0, 0, 0, 0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
